// File: rtl/nibble_serial_add_arbiter_if.sv
// rtl/nibble_serial_add_arbiter_if.sv - request/result handshake bundle for the shared nibble adder
interface nibble_serial_add_arbiter_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic         res_valid;
    logic         res_ready;
    logic [W:0]   res_sum;
    logic         res_id;

    // master: operand sources plus result consumer; slave: the arbiter/adder
    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_sum, res_id,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_sum, res_id,
        input  res_ready
    );
endinterface

// File: rtl/nibble_serial_add_arbiter.sv
// rtl/nibble_serial_add_arbiter.sv - round-robin shared 4-bit adder sequencing W-bit sums nibble by nibble
module nibble_serial_add_arbiter #(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    nibble_serial_add_arbiter_if.slave   bus,
    output logic                         busy
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [W-1:0]     sum_acc;
    logic [W-1:0]     sum_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             last_id;

    logic             grant;
    logic             grant_valid;
    logic             take;
    logic             last_nibble;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       nib_sum;

    logic [W:0]       res_sum_q;
    logic             res_valid_q;
    logic             res_id_q;

    // Round-robin: a tie goes to the port that was not served last.
    always_comb begin
        grant       = 1'b0;
        grant_valid = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant       = ~last_id;
            grant_valid = 1'b1;
        end else if (bus.req1_valid) begin
            grant       = 1'b1;
            grant_valid = 1'b1;
        end else if (bus.req0_valid) begin
            grant       = 1'b0;
            grant_valid = 1'b1;
        end
    end

    always_comb begin
        a_nib   = op_a[{idx, 2'b00} +: 4];
        b_nib   = op_b[{idx, 2'b00} +: 4];
        nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
        sum_nxt = sum_acc;
        sum_nxt[{idx, 2'b00} +: 4] = nib_sum[3:0];
    end

    assign last_nibble = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        take           = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req0_ready = grant_valid && !grant;
                bus.req1_ready = grant_valid && grant;
                take           = grant_valid;
                if (grant_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_nibble) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // No bypass: the next accept waits for IDLE on the following cycle.
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a        <= '0;
            op_b        <= '0;
            sum_acc     <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            last_id     <= 1'b1;
            res_sum_q   <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        op_a     <= grant ? bus.req1_a : bus.req0_a;
                        op_b     <= grant ? bus.req1_b : bus.req0_b;
                        res_id_q <= grant;
                        last_id  <= grant;
                        sum_acc  <= '0;
                        idx      <= '0;
                        carry    <= 1'b0;
                    end
                end
                RUN: begin
                    sum_acc <= sum_nxt;
                    carry   <= nib_sum[4];
                    idx     <= idx + IDX_W'(1);
                    if (last_nibble) begin
                        res_sum_q   <= {nib_sum[4], sum_nxt};
                        res_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_id    = res_id_q;
    assign busy          = (state == RUN) || (state == DONE);

endmodule
